// File: rtl/fp32_mul.sv
// fp32_mul: single-cycle IEEE-754 binary32 multiplier, RNE rounding, flush-to-zero, registered output.
module fp32_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] r_result;
  logic [31:0] w_res;
  logic        w_sign;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [47:0] w_prod;
  logic        w_hi;
  logic [22:0] w_m;
  logic        w_g, w_r, w_s, w_up;
  logic [23:0] w_mr;
  logic [9:0]  w_e;
  assign w_sign   = a[31] ^ b[31];
  assign w_a_nan  = (&a[30:23]) & (|a[22:0]);
  assign w_b_nan  = (&b[30:23]) & (|b[22:0]);
  assign w_a_inf  = (&a[30:23]) & ~(|a[22:0]);
  assign w_b_inf  = (&b[30:23]) & ~(|b[22:0]);
  assign w_a_zero = ~(|a[30:23]);
  assign w_b_zero = ~(|b[30:23]);
  assign w_prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
  assign w_hi   = w_prod[47];
  assign w_m    = w_hi ? w_prod[46:24] : w_prod[45:23];
  assign w_g    = w_hi ? w_prod[23] : w_prod[22];
  assign w_r    = w_hi ? w_prod[22] : w_prod[21];
  assign w_s    = w_hi ? |w_prod[21:0] : |w_prod[20:0];
  assign w_up   = w_g & (w_r | w_s | w_m[0]);
  // carry into bit 23 leaves the low 23 bits zero, so only the exponent needs bumping
  assign w_mr   = {1'b0, w_m} + {23'd0, w_up};
  assign w_e    = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'd0, w_hi} + {9'd0, w_mr[23]};
  always_comb begin
    w_res = (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) ? 32'h7FC0_0000 :
            (w_a_inf | w_b_inf)                  ? {w_sign, 8'hFF, 23'd0} :
            (w_a_zero | w_b_zero)                ? {w_sign, 31'd0} :
            ($signed(w_e) >= $signed(10'sd255))  ? {w_sign, 8'hFF, 23'd0} :
            ($signed(w_e) <= $signed(10'sd0))    ? {w_sign, 31'd0} :
                                                   {w_sign, w_e[7:0], w_mr[22:0]};
  end
  always_ff @(posedge clk) r_result <= rst ? 32'd0 : w_res;
  assign result = r_result;
endmodule

// File: tb/tb_fp32_mul.sv
// tb_fp32_mul: directed vector table plus reset/pipeline sequences for fp32_mul.
module tb_fp32_mul;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [31:0] result;
  int total = 0, passed = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    string       name;
  } vec_t;
  vec_t vecs[$];
  fp32_mul dut (.clk(clk), .rst(rst), .a(a), .b(b), .result(result));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] exp);
    total++;
    if (result === exp) passed++;
    else $display("FAIL %s a=%h b=%h got=%h expected=%h", n, a, b, result, exp);
  endtask
  task automatic step(input logic [31:0] ia, input logic [31:0] ib);
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs.push_back('{32'h3F800000, 32'h40000000, 32'h40000000, "one_x_two"});
    vecs.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, "1p5_sq"});
    vecs.push_back('{32'h4F000000, 32'h4F000000, 32'h5E800000, "2p31_sq"});
    vecs.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, "neg_m2_x_3"});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, "round_sticky"});
    vecs.push_back('{32'h3F800001, 32'h3FC00000, 32'h3FC00002, "tie_odd_up"});
    vecs.push_back('{32'h3F800003, 32'h3FC00000, 32'h3FC00004, "tie_even_keep"});
    vecs.push_back('{32'h3FFFF800, 32'h3F800400, 32'h40000000, "round_carry"});
    vecs.push_back('{32'h40A00000, 32'h00000000, 32'h00000000, "norm_x_zero"});
    vecs.push_back('{32'h00000000, 32'h3F800000, 32'h00000000, "zero_x_norm"});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, "negzero_x_norm"});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_x_norm"});
    vecs.push_back('{32'h3F800000, 32'h7F800000, 32'h7F800000, "norm_x_inf"});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000, "neginf_x_norm"});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero"});
    vecs.push_back('{32'h80000000, 32'h7F800000, 32'h7FC00000, "negzero_x_inf"});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_x_norm"});
    vecs.push_back('{32'h3F800000, 32'hFFC00001, 32'h7FC00000, "norm_x_negnan"});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, "overflow"});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, "round_overflow"});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, "max_x_one"});
    vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, "underflow"});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, "min_normal"});
    vecs.push_back('{32'h00400000, 32'h7F800000, 32'h7FC00000, "denorm_x_inf"});
    vecs.push_back('{32'h80400000, 32'h40000000, 32'h80000000, "negdenorm_ftz"});
    rst = 1'b1;
    step(32'h3F800000, 32'h40000000);
    chk("reset_0", 32'h00000000);
    step(32'h3F800000, 32'h40000000);
    chk("reset_1", 32'h00000000);
    rst = 1'b0;
    step(32'h3F800000, 32'h40000000);
    chk("reset_release", 32'h40000000);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].a, vecs[i].b);
      chk(vecs[i].name, vecs[i].y);
    end
    step(32'h40400000, 32'h40000000);
    chk("pre_flush", 32'h40C00000);
    rst = 1'b1;
    step(32'h40400000, 32'h40400000);
    chk("flush_in_flight", 32'h00000000);
    rst = 1'b0;
    step(32'h40400000, 32'h40000000);
    chk("after_flush", 32'h40C00000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp32_mul.md
FP32_MUL -- requirements
Module: fp32_mul

Interface
Parameters: none.
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 a  input  32 (Float32: sign[31], exp[30:23], mant[22:0])  multiplicand, IEEE-754 binary32.
REQ-005 b  input  32 (Float32)  multiplier, IEEE-754 binary32.
REQ-006 result  output  32 (Float32)  registered product a*b.

Function
REQ-007 Latency SHALL be exactly 1 cycle: result at edge N+1 reflects a, b sampled at edge N. No handshake; one new operation accepted every cycle.
REQ-008 Operand classes: exp==255 and mant!=0 -> NaN; exp==255 and mant==0 -> Inf; exp==0 (any mant) -> zero, with denormal inputs flushed to zero and sign kept; otherwise normal with implicit leading 1.
REQ-009 Sign of every non-NaN result SHALL be sign(a) XOR sign(b).
REQ-010 Special-case priority: NaN operand -> 32'h7FC00000; Inf*zero (either order) -> 32'h7FC00000; Inf*(Inf or normal) -> signed Inf (exp 255, mant 0); zero*(zero or normal) -> signed zero.
REQ-011 All NaN outputs SHALL be the canonical quiet NaN 32'h7FC00000 (sign 0); input NaN payloads are not propagated.
REQ-012 Normal*normal: 24x24 unsigned significand product (48 bits); biased exponent = ea + eb - 127, computed at 10 bits signed width so overflow and underflow cannot wrap.
REQ-013 Normalization: if product bit 47 is set, shift right 1 and increment exponent; the leading 1 is then bit 46.
REQ-014 Rounding SHALL be round-to-nearest, ties-to-even, using guard, round and sticky (OR of all discarded lower bits).
REQ-015 A rounding carry out of the mantissa (1.111..1 -> 10.000..0) SHALL renormalize: mantissa 0, exponent +1.
REQ-016 Overflow: final biased exponent >= 255 -> signed Inf.
REQ-017 Underflow: final biased exponent <= 0 -> signed zero (flush-to-zero; denormal results are never produced).
REQ-018 Exact results SHALL be bit-exact IEEE-754, e.g. 1.0*2.0 = 32'h40000000.
REQ-019 Datapath is combinational from a, b to one output register; no multicycle paths.

Reset
REQ-020 While rst is high at a rising edge, result SHALL load 32'h00000000 regardless of a and b.
REQ-021 On the first rising edge with rst low, result SHALL reflect the a, b sampled at that edge; an operation in flight when reset asserts is discarded.
REQ-022 No output is defined before the first clock edge; the bench asserts rst for at least 1 cycle.

Verification
REQ-023 Exact and rounding: a=3F800000, b=40000000 -> 40000000 next cycle; a=3FC00000, b=3FC00000 -> 40100000; a=4F000000, b=4F000000 (2^31*2^31 = 2^62) -> 5E800000.
REQ-024 Zeros: a=40A00000, b=00000000 -> 00000000; a=00000000, b=3F800000 -> 00000000; a=80000000, b=3F800000 -> 80000000.
REQ-025 Infinity and NaN: a=7F800000, b=3F800000 -> 7F800000; a=3F800000, b=7F800000 -> 7F800000; a=7F800000, b=00000000 -> 7FC00000; a=7FC00000, b=3F800000 -> 7FC00000; a=3F800000, b=7FC00000 -> 7FC00000.
REQ-026 Overflow and underflow: a=7F000000, b=40000000 -> 7F800000; a=00800000, b=00800000 -> 00000000; a=00400000 (denormal), b=7F800000 -> 7FC00000.
REQ-027 Reset and pipelining: hold rst=1 with a=3F800000, b=40000000 -> result 00000000; release rst -> result 40000000 on the next edge. Back-to-back inputs, one per cycle, each appear exactly 1 cycle later in order.
